// File: rtl/probe_drop_pkg.sv
// Shared types and helpers for the probe drop collector.
// The defaults below match the production configuration; the top re-derives widths from its parameters.
package probe_drop_pkg;

  localparam int PD_REGIONS    = 2;
  localparam int PD_TS_W       = 32;
  localparam int PD_CNT_W      = 48;
  localparam int PD_FIFO_DEPTH = 16;
  localparam int PD_PC_W       = $clog2(PD_REGIONS + 1);

  typedef struct packed {
    logic [PD_TS_W-1:0]    ts;
    logic [PD_REGIONS-1:0] eof;
    logic [PD_REGIONS-1:0] drop;
  } probe_evt_t;

  function automatic logic [PD_PC_W-1:0] popcount(input logic [PD_REGIONS-1:0] v);
    logic [PD_PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < PD_REGIONS; i++) n = n + PD_PC_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/probe_evt_fifo.sv
// Synchronous show-ahead FIFO holding drop events.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module probe_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_wr, do_rd;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  // A write into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_rd  = rd_en_i & ~empty_o;
  assign do_wr  = wr_en_i & (~full_o | do_rd);
  assign wptr_d = do_wr ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d = do_rd ? rptr_q + (AW+1)'(1) : rptr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/probe_drop_collector.sv
// Sink of the RX MAC drop probe: counts frames/drops per port and queues
// per-cycle drop events with a timestamp for a scoreboard or MI reader.
module probe_drop_collector
  import probe_drop_pkg::*;
#(
  parameter int REGIONS    = PD_REGIONS,
  parameter int TS_W       = PD_TS_W,
  parameter int CNT_W      = PD_CNT_W,
  parameter int FIFO_DEPTH = PD_FIFO_DEPTH
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 PROBE_VLD,
  input  logic [2*REGIONS-1:0] PROBE_DATA,
  output logic                 EV_VLD,
  input  logic                 EV_RDY,
  output logic [TS_W-1:0]      EV_TS,
  output logic [REGIONS-1:0]   EV_EOF,
  output logic [REGIONS-1:0]   EV_DROP,
  input  logic                 CNT_CLR,
  output logic [CNT_W-1:0]     FRAME_CNT,
  output logic [CNT_W-1:0]     DROP_CNT,
  output logic [CNT_W-1:0]     LOST_CNT,
  output logic                 OVERFLOW
);

  localparam int PC_W = $clog2(REGIONS + 1);

  typedef struct packed {
    logic [TS_W-1:0]    ts;
    logic [REGIONS-1:0] eof;
    logic [REGIONS-1:0] drop;
  } evt_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [PC_W-1:0]  inc);
    logic [CNT_W:0] s;
    s = {1'b0, base} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [TS_W-1:0]      ts_q;
  logic                 s1_vld_q;
  logic [2*REGIONS-1:0] s1_data_q;
  logic [TS_W-1:0]      s1_ts_q;
  logic [CNT_W-1:0]     frame_q, frame_d, drop_q, drop_d, lost_q, lost_d;
  logic                 ovf_q, ovf_d;

  logic [REGIONS-1:0]   eof, dmask;
  logic [PC_W-1:0]      eof_n, drp_n;
  logic                 push, pop, lost, fifo_full, fifo_empty;
  evt_t                 wr_evt, rd_evt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ts_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_ts_q   <= '0;
      frame_q   <= '0;
      drop_q    <= '0;
      lost_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ts_q      <= ts_q + TS_W'(1);
      s1_vld_q  <= PROBE_VLD;
      s1_data_q <= PROBE_DATA;
      s1_ts_q   <= ts_q;
      frame_q   <= frame_d;
      drop_q    <= drop_d;
      lost_q    <= lost_d;
      ovf_q     <= ovf_d;
    end
  end

  // force_drop only means something in a region that also ends a frame.
  assign eof   = s1_data_q[2*REGIONS-1:REGIONS];
  assign dmask = eof & s1_data_q[REGIONS-1:0];

  always_comb begin
    eof_n = '0;
    drp_n = '0;
    for (int i = 0; i < REGIONS; i++) begin
      eof_n = eof_n + PC_W'(eof[i] & s1_vld_q);
      drp_n = drp_n + PC_W'(dmask[i] & s1_vld_q);
    end
  end

  assign push = s1_vld_q & (|eof);
  assign pop  = ~fifo_empty & EV_RDY;
  assign lost = push & fifo_full & ~pop;

  // Clear first, then add this cycle's increment.
  assign frame_d = sat_add(CNT_CLR ? '0 : frame_q, eof_n);
  assign drop_d  = sat_add(CNT_CLR ? '0 : drop_q, drp_n);
  assign lost_d  = sat_add(CNT_CLR ? '0 : lost_q, PC_W'(lost));
  assign ovf_d   = lost | (ovf_q & ~CNT_CLR);

  assign wr_evt = '{ts: s1_ts_q, eof: eof, drop: dmask};

  probe_evt_fifo #(
    .W     ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_n_i   (RESET_N),
    .wr_en_i   (push & ~lost),
    .wr_data_i (wr_evt),
    .rd_en_i   (pop),
    .rd_data_o (rd_evt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Event fields read as zero while nothing is queued.
  assign EV_VLD    = ~fifo_empty;
  assign EV_TS     = EV_VLD ? rd_evt.ts   : '0;
  assign EV_EOF    = EV_VLD ? rd_evt.eof  : '0;
  assign EV_DROP   = EV_VLD ? rd_evt.drop : '0;
  assign FRAME_CNT = frame_q;
  assign DROP_CNT  = drop_q;
  assign LOST_CNT  = lost_q;
  assign OVERFLOW  = ovf_q;

endmodule
